// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: N bits split into STAGES slices, one slice per clock.
// Optional saturation on signed overflow when ADDSUB_SAT_EN is defined.
module addsub_pipe #(
    parameter int N      = 24,
    parameter int STAGES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         ovf,
    output logic         zero
);

    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe advances as one (en); bubbles are kept, not squeezed out.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RW = N - k * W;

        logic [RW-1:0]        ra;
        logic [RW-1:0]        rb;
        logic                 cy;
        logic                 vin;
        logic [W:0]           sl;
        logic [(k+1)*W-1:0]   nlo;

        assign sl = {1'b0, ra[W-1:0]} + {1'b0, rb[W-1:0]} + {{W{1'b0}}, cy};

        if (k == 0) begin : g_src
            // Subtraction is A + ~B + 1: invert B once here and feed sub as the first carry.
            assign ra  = a;
            assign rb  = b ^ {N{sub}};
            assign cy  = sub;
            assign vin = in_valid;
            assign nlo = sl[W-1:0];
        end else begin : g_src
            assign ra  = g_stage[k-1].g_pipe.ra_q;
            assign rb  = g_stage[k-1].g_pipe.rb_q;
            assign cy  = g_stage[k-1].g_pipe.cy_q;
            assign vin = g_stage[k-1].g_pipe.vld_q;
            assign nlo = {sl[W-1:0], g_stage[k-1].g_pipe.lo_q};
        end

        if (k < L) begin : g_pipe
            logic [RW-W-1:0]    ra_q;
            logic [RW-W-1:0]    rb_q;
            logic [(k+1)*W-1:0] lo_q;
            logic               cy_q;
            logic               vld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra_q  <= '0;
                    rb_q  <= '0;
                    lo_q  <= '0;
                    cy_q  <= 1'b0;
                    vld_q <= 1'b0;
                end else if (en) begin
                    ra_q  <= ra[RW-1:W];
                    rb_q  <= rb[RW-1:W];
                    lo_q  <= nlo;
                    cy_q  <= sl[W];
                    vld_q <= vin;
                end
            end
        end else begin : g_out
            logic         c_fin;
            logic         v_fin;
            logic [N-1:0] res;

            // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ sum.
            assign c_fin = sl[W];
            assign v_fin = (ra[W-1] ^ rb[W-1] ^ sl[W-1]) ^ sl[W];

`ifdef ADDSUB_SAT_EN
            // The MSB of A tells which direction overflowed.
            assign res = !v_fin ? nlo :
                         (ra[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}});
`else
            assign res = nlo;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    s         <= '0;
                    c_out     <= 1'b0;
                    ovf       <= 1'b0;
                    zero      <= 1'b0;
                end else if (en) begin
                    out_valid <= vin;
                    s         <= res;
                    c_out     <= c_fin;
                    ovf       <= v_fin;
                    zero      <= (res == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: directed vectors, back-pressure, reset mid-flight and random traffic
// checked against an arithmetic reference model.
module tb_addsub_pipe;

    localparam int N      = 24;
    localparam int STAGES = 3;
    localparam int EW     = N + 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         c_out;
    logic         ovf;
    logic         zero;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [N-1:0]  corners[5];

    addsub_pipe #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] pk(input logic [N-1:0] ps, input logic pc, input logic pv,
                                         input logic pz);
        return {ps, pc, pv, pz};
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic logic [EW-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                            input logic ms);
        longint unsigned ua, ub, full;
        longint          sa, sb, r, maxp, minn;
        logic [N-1:0]    rs;
        logic            rc, rv;
        ua   = ma;
        ub   = mb;
        full = ms ? ua + ((longint'(1) << N) - ub) : ua + ub;
        rs   = full[N-1:0];
        rc   = full[N];
        sa   = $signed(ma);
        sb   = $signed(mb);
        r    = ms ? sa - sb : sa + sb;
        maxp = (longint'(1) << (N - 1)) - 1;
        minn = -(longint'(1) << (N - 1));
        rv   = (r > maxp) || (r < minn);
`ifdef ADDSUB_SAT_EN
        if (rv) rs = (r > 0) ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
`endif
        return {rs, rc, rv, (rs == '0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [N-1:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return N'($urandom);
    endfunction

    // ---------------- driver ----------------
    task automatic send_exp(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic ts,
                            input logic [EW-1:0] e);
        int guard;
        guard = 0;
        @(negedge clk);
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        #4;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #4;
            guard++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_rnd();
        logic [N-1:0] ta, tb;
        logic         ts;
        ta = rnd_op();
        tb = rnd_op();
        ts = 1'($urandom_range(0, 1));
        send_exp(ta, tb, ts, model(ta, tb, ts));
    endtask

    // Single op into an empty pipe; the accept edge counts as cycle 1.
    task automatic lat_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic ts,
                          input logic [EW-1:0] e);
        int n;
        send_exp(ta, tb, ts, e);
        n = 1;
        while (n < 12) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
        check("latency", 64'(n), 64'(STAGES));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        #3;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
                check("result", 64'({s, c_out, ovf, zero}), 64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
                else check("stall_in_ready", 64'(in_ready), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic done;
        corners[0] = 24'h000000;
        corners[1] = 24'hFFFFFF;
        corners[2] = 24'h7FFFFF;
        corners[3] = 24'h800000;
        corners[4] = 24'h000001;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_flags_s", 64'({s, c_out, ovf, zero}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Carry out of slice 0 into slice 1, with latency
        lat_op(24'h000001, 24'h0000FF, 1'b0, pk(24'h000100, 1'b0, 1'b0, 1'b0));
        drain();

        // Subtract to zero, then borrow
        send_exp(24'h123456, 24'h123456, 1'b1, pk(24'h000000, 1'b1, 1'b0, 1'b1));
        send_exp(24'h000000, 24'h000001, 1'b1, pk(24'hFFFFFF, 1'b0, 1'b0, 1'b0));
        drain();

        // Signed overflow in both directions
`ifdef ADDSUB_SAT_EN
        send_exp(24'h7FFFFF, 24'h000001, 1'b0, pk(24'h7FFFFF, 1'b0, 1'b1, 1'b0));
        send_exp(24'h800000, 24'h000001, 1'b1, pk(24'h800000, 1'b1, 1'b1, 1'b0));
`else
        send_exp(24'h7FFFFF, 24'h000001, 1'b0, pk(24'h800000, 1'b0, 1'b1, 1'b0));
        send_exp(24'h800000, 24'h000001, 1'b1, pk(24'h7FFFFF, 1'b1, 1'b1, 1'b0));
`endif
        drain();

        // Back-pressure: six back-to-back ops, stall four cycles after the first result
        fork
            begin
                for (int i = 0; i < 6; i++) send_rnd();
            end
            begin
                int g;
                g = 0;
                while (!out_valid && g < 50) begin
                    @(negedge clk);
                    g++;
                end
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Full ripple with neighbours in the other slices
        send_exp(24'h111111, 24'h0F0F0F, 1'b0, pk(24'h202020, 1'b0, 1'b0, 1'b0));
        send_exp(24'hFFFFFF, 24'h000001, 1'b0, pk(24'h000000, 1'b1, 1'b0, 1'b1));
        send_exp(24'h00F000, 24'h001000, 1'b1, pk(24'h00E000, 1'b1, 1'b0, 1'b0));
        drain();

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) send_rnd();
        #1 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_s", 64'(s), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #3;
            check("no_stale_after_reset", 64'(out_valid), 64'd0);
        end
        lat_op(24'h000FFF, 24'h000001, 1'b0, pk(24'h001000, 1'b0, 1'b0, 1'b0));
        drain();

        // Random traffic with random back-pressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send_rnd();
                    if ($urandom_range(0, 4) == 0) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                int g;
                g = 0;
                while (!done && g < 3000) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                    g++;
                end
                out_ready = 1'b1;
            end
        join
        @(negedge clk);
        out_ready = 1'b1;
        drain();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
